// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined adder: operation modes and the
// carry-chain slice width helper.
package adder_pkg;

    localparam logic ADD_OP = 1'b0;
    localparam logic SUB_OP = 1'b1;

    // Bits of the carry chain resolved by each pipeline stage.
    function automatic int slice_width(input int width, input int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operation request / result channel of the pipelined adder.
// The master drives operations and accepts results; the slave is the adder.
interface pipe_adder_if #(
    parameter int WIDTH = 32
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, operand1, operand2, cin, sub, out_ready,
        input  in_ready, out_valid, result, cout, overflow
    );

    modport slave (
        input  in_valid, operand1, operand2, cin, sub, out_ready,
        output in_ready, out_valid, result, cout, overflow
    );

endinterface

// File: rtl/pipe_adder_slice.sv
// One C-bit slice of the pipelined carry chain plus its pipeline register.
// Word a carries finished sum bits below the slice and raw operand1 bits above.
module add_slice
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int C     = 16,
    parameter int IDX   = 0,
    parameter bit LAST  = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_carry,
    output logic             out_ovf
);

    logic [C:0]       sum;
    logic [WIDTH-1:0] a_next;
    logic             msb_carry;
    logic             ovf_next;
    logic             load;

    assign sum = {1'b0, in_a[IDX*C +: C]} + {1'b0, in_b[IDX*C +: C]} + {{C{1'b0}}, in_carry};

    always_comb begin
        // NOTE: assign the whole word before patching the slice so no bit is left unassigned (no latch).
        a_next             = in_a;
        a_next[IDX*C +: C] = sum[C-1:0];
    end

    // Only the top slice sees the MSB; carry into it is recovered from the sum bit.
    assign msb_carry = in_a[WIDTH-1] ^ in_b[WIDTH-1] ^ sum[C-1];
    assign ovf_next  = LAST && (msb_carry ^ sum[C]);

    // An empty stage, or one whose occupant leaves this cycle, can take new data.
    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_carry <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples pre-edge values of its neighbours.
            if (in_ready) begin
                out_valid <= in_valid;
            end
            if (load) begin
                out_a     <= a_next;
                out_b     <= in_b;
                out_carry <= sum[C];
                out_ovf   <= ovf_next;
            end
        end
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: the carry chain is split into STAGES slices,
// one per register, joined by a single combinational ready chain.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         resetn,
    pipe_adder_if.slave  bus
);

    localparam int C = slice_width(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > 8 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipe_adder: STAGES must be 1..8 and divide WIDTH");
    end

    // Subtract is a + ~b + ~borrow on the same adder.
    logic [WIDTH-1:0] b_eff;
    logic             carry_eff;

    assign b_eff     = (bus.sub == SUB_OP) ? ~bus.operand2 : bus.operand2;
    assign carry_eff = (bus.sub == ADD_OP) ? bus.cin : ~bus.cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_a;
        logic [WIDTH-1:0] up_b;
        logic             up_carry;
        logic             rdy;
        logic             dn_ready;
        logic             v;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             c;
        logic             ov;

        if (k == 0) begin : g_head
            assign up_valid     = bus.in_valid;
            assign up_a         = bus.operand1;
            assign up_b         = b_eff;
            assign up_carry     = carry_eff;
            assign bus.in_ready = rdy;
        end else begin : g_body
            assign up_valid = g_stage[k-1].v;
            assign up_a     = g_stage[k-1].a;
            assign up_b     = g_stage[k-1].b;
            assign up_carry = g_stage[k-1].c;
        end

        if (k == STAGES - 1) begin : g_tail
            logic unused_tail;
            assign dn_ready      = bus.out_ready;
            assign bus.out_valid = v;
            assign bus.result    = a;
            assign bus.cout      = c;
            assign bus.overflow  = ov;
            assign unused_tail   = ^b;
        end else begin : g_link
            logic unused_ovf;
            assign dn_ready   = g_stage[k+1].rdy;
            assign unused_ovf = ov;
        end

        add_slice #(
            .WIDTH (WIDTH),
            .C     (C),
            .IDX   (k),
            .LAST  (k == STAGES - 1)
        ) u_slice (
            .clk       (clk),
            .resetn    (resetn),
            .in_valid  (up_valid),
            .in_ready  (rdy),
            .in_a      (up_a),
            .in_b      (up_b),
            .in_carry  (up_carry),
            .out_valid (v),
            .out_ready (dn_ready),
            .out_a     (a),
            .out_b     (b),
            .out_carry (c),
            .out_ovf   (ov)
        );
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder across four WIDTH/STAGES configurations,
// plus a scoreboarded stream on the four-stage instance.
module tb_pipe_adder;
    import adder_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_adder_if #(.WIDTH(32)) bus2 ();
    pipe_adder_if #(.WIDTH(32)) bus4 ();
    pipe_adder_if #(.WIDTH(8))  bus1 ();
    pipe_adder_if #(.WIDTH(64)) bus8 ();

    pipe_adder #(.WIDTH(32), .STAGES(2)) u2 (.clk(clk), .resetn(resetn), .bus(bus2));
    pipe_adder #(.WIDTH(32), .STAGES(4)) u4 (.clk(clk), .resetn(resetn), .bus(bus4));
    pipe_adder #(.WIDTH(8),  .STAGES(1)) u1 (.clk(clk), .resetn(resetn), .bus(bus1));
    pipe_adder #(.WIDTH(64), .STAGES(8)) u8 (.clk(clk), .resetn(resetn), .bus(bus8));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb);
        bus2.in_valid = 1'b1;
        bus2.operand1 = a;
        bus2.operand2 = b;
        bus2.cin      = ci;
        bus2.sub      = sb;
    endtask

    // Expected {overflow, cout, result}; subtraction modelled as a - b - borrow.
    function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                            input logic ci, input logic sb);
        logic [32:0] full;
        logic        ov;
        if (sb == SUB_OP) begin
            full = {1'b0, a} - {1'b0, b} - {32'd0, ci};
            ov   = (a[31] != b[31]) && (full[31] != a[31]);
            return {ov, ~full[32], full[31:0]};
        end
        full = {1'b0, a} + {1'b0, b} + {32'd0, ci};
        ov   = (a[31] == b[31]) && (full[31] != a[31]);
        return {ov, full[32], full[31:0]};
    endfunction

    logic [33:0] sb_q[$];
    logic [33:0] exp_v;
    logic [33:0] held_v;
    logic [31:0] ra, rb;
    logic        rc, rs;
    logic        held;
    int          sent, got, first_out, last_out, stalls;

    initial begin
        resetn = 1'b0;
        bus2.in_valid = 1'b0; bus2.operand1 = '0; bus2.operand2 = '0; bus2.cin = 1'b0; bus2.sub = 1'b0; bus2.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.operand1 = '0; bus4.operand2 = '0; bus4.cin = 1'b0; bus4.sub = 1'b0; bus4.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.operand1 = '0; bus1.operand2 = '0; bus1.cin = 1'b0; bus1.sub = 1'b0; bus1.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.operand1 = '0; bus8.operand2 = '0; bus8.cin = 1'b0; bus8.sub = 1'b0; bus8.out_ready = 1'b1;

        // Reset state
        #12;
        check("reset out_valid", 128'(bus2.out_valid), 128'(0));
        check("reset data", 128'({bus2.overflow, bus2.cout, bus2.result}), 128'(0));
        check("reset in_ready", 128'(bus2.in_ready), 128'(1));
        check("reset out_valid w64", 128'(bus8.out_valid), 128'(0));
        step();
        step();
        resetn = 1'b1;
        #1;
        check("in_ready after release", 128'(bus2.in_ready), 128'(1));

        // Add with carry crossing the 16-bit slice boundary
        drive2(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, ADD_OP);
        #1;
        check("add in_ready", 128'(bus2.in_ready), 128'(1));
        step();
        bus2.in_valid = 1'b0;
        check("add latency early", 128'(bus2.out_valid), 128'(0));
        step();
        check("add out_valid", 128'(bus2.out_valid), 128'(1));
        check("add result", 128'({bus2.overflow, bus2.cout, bus2.result}), 128'({1'b0, 1'b1, 32'h0}));
        step();
        check("add drained", 128'(bus2.out_valid), 128'(0));

        // Subtract, back to back
        drive2(32'h8000_0000, 32'h0000_0001, 1'b0, SUB_OP);
        step();
        drive2(32'h0000_0000, 32'h0000_0001, 1'b0, SUB_OP);
        step();
        bus2.in_valid = 1'b0;
        check("sub min-1", 128'({bus2.out_valid, bus2.overflow, bus2.cout, bus2.result}),
              128'({1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF}));
        step();
        check("sub 0-1", 128'({bus2.out_valid, bus2.overflow, bus2.cout, bus2.result}),
              128'({1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF}));
        drive2(32'd10, 32'd3, 1'b1, SUB_OP);
        step();
        bus2.in_valid = 1'b0;
        step();
        check("sub with borrow", 128'({bus2.out_valid, bus2.overflow, bus2.cout, bus2.result}),
              128'({1'b1, 1'b0, 1'b1, 32'd6}));
        step();

        // Full stall: two accepted, third refused, ready returns with out_ready
        bus2.out_ready = 1'b0;
        drive2(32'd10, 32'd20, 1'b0, ADD_OP);
        #1;
        check("stall accept A", 128'(bus2.in_ready), 128'(1));
        step();
        drive2(32'd100, 32'd1, 1'b0, SUB_OP);
        #1;
        check("stall accept B", 128'(bus2.in_ready), 128'(1));
        step();
        drive2(32'd7, 32'd8, 1'b1, ADD_OP);
        #1;
        check("stall in_ready full", 128'(bus2.in_ready), 128'(0));
        check("stall head A", 128'({bus2.out_valid, bus2.overflow, bus2.cout, bus2.result}),
              128'({1'b1, 1'b0, 1'b0, 32'h1E}));
        step();
        check("stall still full", 128'(bus2.in_ready), 128'(0));
        check("stall A held", 128'({bus2.out_valid, bus2.overflow, bus2.cout, bus2.result}),
              128'({1'b1, 1'b0, 1'b0, 32'h1E}));
        bus2.out_ready = 1'b1;
        #1;
        check("ready same cycle", 128'(bus2.in_ready), 128'(1));
        step();
        bus2.in_valid = 1'b0;
        check("stall B", 128'({bus2.out_valid, bus2.overflow, bus2.cout, bus2.result}),
              128'({1'b1, 1'b0, 1'b1, 32'd99}));
        step();
        check("stall C", 128'({bus2.out_valid, bus2.overflow, bus2.cout, bus2.result}),
              128'({1'b1, 1'b0, 1'b0, 32'd16}));
        step();
        check("stall drained", 128'(bus2.out_valid), 128'(0));

        // Asynchronous reset with two ops in flight
        drive2(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, ADD_OP);
        step();
        drive2(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, ADD_OP);
        step();
        bus2.in_valid = 1'b0;
        check("pre-reset X", 128'({bus2.out_valid, bus2.overflow, bus2.cout, bus2.result}),
              128'({1'b1, 1'b1, 1'b0, 32'h8000_0000}));
        #2;
        resetn = 1'b0;
        #1;
        check("async reset outputs", 128'({bus2.out_valid, bus2.overflow, bus2.cout, bus2.result}), 128'(0));
        check("async reset in_ready", 128'(bus2.in_ready), 128'(1));
        step();
        step();
        resetn = 1'b1;
        #1;
        check("no stale after reset", 128'(bus2.out_valid), 128'(0));
        drive2(32'd5, 32'd3, 1'b0, ADD_OP);
        step();
        bus2.in_valid = 1'b0;
        check("post-reset early", 128'(bus2.out_valid), 128'(0));
        step();
        check("post-reset 5+3", 128'({bus2.out_valid, bus2.overflow, bus2.cout, bus2.result}),
              128'({1'b1, 1'b0, 1'b0, 32'd8}));
        step();

        // WIDTH=8, STAGES=1
        bus1.in_valid = 1'b1; bus1.operand1 = 8'hFF; bus1.operand2 = 8'h01; bus1.cin = 1'b0; bus1.sub = ADD_OP;
        step();
        bus1.operand1 = 8'h80; bus1.operand2 = 8'h01; bus1.sub = SUB_OP;
        check("w8 ripple", 128'({bus1.out_valid, bus1.overflow, bus1.cout, bus1.result}),
              128'({1'b1, 1'b0, 1'b1, 8'h00}));
        step();
        bus1.in_valid = 1'b0;
        check("w8 sub overflow", 128'({bus1.out_valid, bus1.overflow, bus1.cout, bus1.result}),
              128'({1'b1, 1'b1, 1'b1, 8'h7F}));
        step();
        check("w8 drained", 128'(bus1.out_valid), 128'(0));

        // WIDTH=64, STAGES=8: carry ripples through every slice
        bus8.in_valid = 1'b1; bus8.operand1 = {64{1'b1}}; bus8.operand2 = 64'd1; bus8.cin = 1'b0; bus8.sub = ADD_OP;
        step();
        bus8.in_valid = 1'b0;
        repeat (6) step();
        check("w64 latency early", 128'(bus8.out_valid), 128'(0));
        step();
        check("w64 ripple", 128'({bus8.out_valid, bus8.overflow, bus8.cout, bus8.result}),
              128'({1'b1, 1'b0, 1'b1, 64'h0}));
        step();

        // STAGES=4 stream, always ready: one result per cycle, in order
        sent = 0; got = 0; first_out = -1; last_out = -1; stalls = 0;
        for (int cyc = 0; cyc < 110; cyc++) begin
            if (sent < 100) begin
                ra = $urandom; rb = $urandom;
                rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
                bus4.in_valid = 1'b1; bus4.operand1 = ra; bus4.operand2 = rb; bus4.cin = rc; bus4.sub = rs;
            end else begin
                bus4.in_valid = 1'b0;
            end
            bus4.out_ready = 1'b1;
            #1;
            if (bus4.in_valid && !bus4.in_ready) stalls++;
            if (bus4.in_valid && bus4.in_ready) begin
                sb_q.push_back(model32(ra, rb, rc, rs));
                sent++;
            end
            if (bus4.out_valid) begin
                check("stream queue nonempty", 128'(sb_q.size() > 0), 128'(1));
                if (sb_q.size() > 0) begin
                    exp_v = sb_q.pop_front();
                    check("stream result", 128'({bus4.overflow, bus4.cout, bus4.result}), 128'(exp_v));
                end
                if (got == 0) first_out = cyc;
                got++;
                last_out = cyc;
            end
            step();
        end
        check("stream no input stall", 128'(stalls), 128'(0));
        check("stream first latency", 128'(first_out), 128'(4));
        check("stream last cycle", 128'(last_out), 128'(103));
        check("stream count", 128'(got), 128'(100));

        // STAGES=4 stream with random backpressure
        sent = 0; got = 0; held = 1'b0; held_v = '0;
        for (int cyc = 0; cyc < 3000 && got < 100; cyc++) begin
            if (sent < 100) begin
                ra = $urandom; rb = $urandom;
                rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
                bus4.in_valid = 1'($urandom_range(0, 1));
                bus4.operand1 = ra; bus4.operand2 = rb; bus4.cin = rc; bus4.sub = rs;
            end else begin
                bus4.in_valid = 1'b0;
            end
            bus4.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (held) begin
                check("stall data stable", 128'({bus4.out_valid, bus4.overflow, bus4.cout, bus4.result}),
                      128'({1'b1, held_v}));
            end
            if (bus4.in_valid && bus4.in_ready) begin
                sb_q.push_back(model32(ra, rb, rc, rs));
                sent++;
            end
            if (bus4.out_valid && bus4.out_ready) begin
                check("bp queue nonempty", 128'(sb_q.size() > 0), 128'(1));
                if (sb_q.size() > 0) begin
                    exp_v = sb_q.pop_front();
                    check("bp result", 128'({bus4.overflow, bus4.cout, bus4.result}), 128'(exp_v));
                end
                got++;
            end
            held   = bus4.out_valid && !bus4.out_ready;
            held_v = {bus4.overflow, bus4.cout, bus4.result};
            step();
        end
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b1;
        check("bp sent", 128'(sent), 128'(100));
        check("bp received", 128'(got), 128'(100));
        check("bp scoreboard empty", 128'(sb_q.size()), 128'(0));
        repeat (5) step();
        check("bp no duplicates", 128'(bus4.out_valid), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
